// File: rtl/vesp1_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : vesp1_pkg                                                       |
// | Brief    : Shared opcodes, FSM states and address map for the vesp1 core.  |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
package vesp1_pkg;

   localparam int DEF_WORD_SIZE    = 16;
   localparam int DEF_ADDRESS_SIZE = 12;

   // Registers A and B live in memory; word 2 is reserved.
   localparam logic [11:0] A_ADDR   = 12'h000;
   localparam logic [11:0] B_ADDR   = 12'h001;
   localparam logic [11:0] RESET_PC = 12'h003;

   localparam logic [3:0] ADD = 4'h0;
   localparam logic [3:0] CMP = 4'h1;
   localparam logic [3:0] LDA = 4'h2;
   localparam logic [3:0] MOV = 4'h3;
   localparam logic [3:0] JMP = 4'h4;
   localparam logic [3:0] JMZ = 4'h5;
   localparam logic [3:0] JMN = 4'h6;
   localparam logic [3:0] HLT = 4'h7;

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      EXEC  = 2'd1,
      EXEC2 = 2'd2,
      HALT  = 2'd3
   } vesp1_state_t;

endpackage
`default_nettype wire

// File: rtl/vesp1_memory.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : vesp1_memory                                                    |
// | Brief    : Unified program/data store, async read ports, one sync write.   |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module vesp1_memory #(
   parameter int WORD_SIZE    = 16,
   parameter int ADDRESS_SIZE = 12
) (
   input  logic                    clk,
   input  logic                    i_we,
   input  logic [ADDRESS_SIZE-1:0] i_waddr,
   input  logic [WORD_SIZE-1:0]    i_wdata,
   input  logic [ADDRESS_SIZE-1:0] i_raddr,
   output logic [WORD_SIZE-1:0]    o_rdata,
   output logic [WORD_SIZE-1:0]    o_a,
   output logic [WORD_SIZE-1:0]    o_b
);

   localparam int c_depth = 2 ** ADDRESS_SIZE;

   // No reset: contents are loaded externally while the core is held in reset.
   logic [WORD_SIZE-1:0] memory [0:c_depth-1];

   always_ff @(posedge clk) begin
      if (i_we) begin
         memory[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata = memory[i_raddr];
   assign o_a     = memory[0];
   assign o_b     = memory[1];

endmodule
`default_nettype wire

// File: rtl/vesp1_risc.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : vesp1_risc                                                      |
// | Brief    : VeSP-style accumulator-in-memory core, multi-cycle fetch/exec.  |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module vesp1_risc
   import vesp1_pkg::*;
#(
   parameter int                            WORD_SIZE    = DEF_WORD_SIZE,
   parameter int                            ADDRESS_SIZE = DEF_ADDRESS_SIZE,
   parameter logic [DEF_ADDRESS_SIZE-1:0]   RESET_VECTOR = RESET_PC
) (
   input  logic clk,
   input  logic rst
);

   localparam logic [ADDRESS_SIZE-1:0] c_pc_one = 1;

   logic [ADDRESS_SIZE-1:0] r_pc;
   logic [WORD_SIZE-1:0]    r_ir;
   logic [ADDRESS_SIZE-1:0] r_mar;
   vesp1_state_t            r_state;

   logic [ADDRESS_SIZE-1:0] w_pc_next;
   logic [WORD_SIZE-1:0]    w_ir_next;
   logic [ADDRESS_SIZE-1:0] w_mar_next;
   vesp1_state_t            w_state_next;

   logic [ADDRESS_SIZE-1:0] w_raddr;
   logic [WORD_SIZE-1:0]    w_rdata;
   logic [WORD_SIZE-1:0]    w_a;
   logic [WORD_SIZE-1:0]    w_b;
   logic                    w_we;
   logic                    w_mem_we;
   logic [ADDRESS_SIZE-1:0] w_waddr;
   logic [WORD_SIZE-1:0]    w_wdata;

   logic [3:0]              w_opcode;
   logic [ADDRESS_SIZE-1:0] w_operand;
   logic [ADDRESS_SIZE-1:0] w_pc_inc;

   assign w_opcode  = r_ir[WORD_SIZE-1 -: 4];
   assign w_operand = r_ir[ADDRESS_SIZE-1:0];
   assign w_pc_inc  = r_pc + c_pc_one;

   // Gating on rst keeps externally preloaded memory intact during reset.
   assign w_mem_we  = w_we & ~rst;

   vesp1_memory #(
      .WORD_SIZE    (WORD_SIZE),
      .ADDRESS_SIZE (ADDRESS_SIZE)
   ) M1 (
      .clk     (clk),
      .i_we    (w_mem_we),
      .i_waddr (w_waddr),
      .i_wdata (w_wdata),
      .i_raddr (w_raddr),
      .o_rdata (w_rdata),
      .o_a     (w_a),
      .o_b     (w_b)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_pc    <= RESET_VECTOR[ADDRESS_SIZE-1:0];
         r_ir    <= '0;
         r_mar   <= '0;
         r_state <= FETCH;
      end else begin
         r_pc    <= w_pc_next;
         r_ir    <= w_ir_next;
         r_mar   <= w_mar_next;
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_pc_next    = r_pc;
      w_ir_next    = r_ir;
      w_mar_next   = r_mar;
      w_raddr      = r_pc;
      w_we         = 1'b0;
      w_waddr      = w_operand;
      w_wdata      = w_rdata;

      unique case (r_state)
         FETCH: begin
            w_ir_next    = w_rdata;
            w_pc_next    = w_pc_inc;
            w_state_next = EXEC;
         end

         EXEC: begin
            w_state_next = FETCH;
            case (w_opcode)
               ADD: begin
                  w_we    = 1'b1;
                  w_waddr = ADDRESS_SIZE'(A_ADDR);
                  w_wdata = w_a + w_b;
               end
               CMP: begin
                  w_we    = 1'b1;
                  w_waddr = ADDRESS_SIZE'(A_ADDR);
                  w_wdata = ~w_a;
               end
               LDA: begin
                  w_we      = 1'b1;
                  w_pc_next = w_pc_inc;
               end
               // Second word of MOV holds the source address.
               MOV: begin
                  w_mar_next   = w_rdata[ADDRESS_SIZE-1:0];
                  w_pc_next    = w_pc_inc;
                  w_state_next = EXEC2;
               end
               JMP: w_pc_next = w_operand;
               JMZ: begin
                  if (w_a == '0) begin
                     w_pc_next = w_operand;
                  end
               end
               JMN: begin
                  if (w_a[WORD_SIZE-1]) begin
                     w_pc_next = w_operand;
                  end
               end
               HLT: w_state_next = HALT;
               default: ;
            endcase
         end

         EXEC2: begin
            w_raddr      = r_mar;
            w_we         = 1'b1;
            w_state_next = FETCH;
         end

         HALT: ;

         default: w_state_next = FETCH;
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_vesp1_risc.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_vesp1_risc                                                   |
// | Brief    : Directed programs with a memory-result scoreboard for vesp1.    |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_vesp1_risc;
   import vesp1_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   vesp1_risc #(
      .WORD_SIZE    (16),
      .ADDRESS_SIZE (12),
      .RESET_VECTOR (12'h003)
   ) dut (
      .clk (clk),
      .rst (rst)
   );

   int total = 0;
   int bad   = 0;

   logic [11:0] q_addr [$];
   logic [15:0] q_data [$];
   string       q_tag  [$];
   logic [15:0] snap   [0:4095];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic load(input logic [11:0] addr, input logic [15:0] data);
      dut.M1.memory[addr] <= data;
   endtask

   task automatic expect_mem(input logic [11:0] addr, input logic [15:0] data, input string tag);
      q_addr.push_back(addr);
      q_data.push_back(data);
      q_tag.push_back(tag);
   endtask

   // Enter reset and clear memory; caller preloads right after.
   task automatic begin_reset();
      rst = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 4096; i++) dut.M1.memory[i] <= 16'h0000;
   endtask

   task automatic release_rst();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic run_to_halt(input int exp_cycles, input string tag);
      int n;
      n = 0;
      while (dut.r_state !== HALT && n < 200) begin
         @(posedge clk);
         n++;
         @(negedge clk);
      end
      check(tag, 32'(n), 32'(exp_cycles));
   endtask

   task automatic drain();
      logic [11:0] a;
      logic [15:0] d;
      string       t;
      while (q_addr.size() > 0) begin
         a = q_addr.pop_front();
         d = q_data.pop_front();
         t = q_tag.pop_front();
         check(t, 32'(dut.M1.memory[a]), 32'(d));
      end
   endtask

   initial begin
      int diffs;

      // Two LDAs, ADD, HLT; reset values checked while rst is held.
      begin_reset();
      load(12'h003, 16'h2000); load(12'h004, 16'h0008);
      load(12'h005, 16'h2001); load(12'h006, 16'h000B);
      load(12'h007, 16'h0000); load(12'h008, 16'h7000);
      expect_mem(12'h000, 16'h0013, "lda_add_m0");
      expect_mem(12'h001, 16'h000B, "lda_add_m1");
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_pc", 32'(dut.r_pc), 32'h003);
      check("rst_ir", 32'(dut.r_ir), 32'h0);
      check("rst_mar", 32'(dut.r_mar), 32'h0);
      check("rst_state", 32'(dut.r_state), 32'(FETCH));
      rst = 1'b0;
      run_to_halt(8, "lda_add_cycles");
      drain();
      for (int i = 0; i < 4096; i++) snap[i] = dut.M1.memory[i];
      repeat (100) @(posedge clk);
      @(negedge clk);
      diffs = 0;
      for (int i = 0; i < 4096; i++) if (dut.M1.memory[i] !== snap[i]) diffs++;
      check("halt_mem_stable", 32'(diffs), 32'h0);
      check("halt_stays", 32'(dut.r_state), 32'(HALT));
      check("halt_pc_stable", 32'(dut.r_pc), 32'h009);

      // Reset taken from HALT.
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("halt_rst_pc", 32'(dut.r_pc), 32'h003);
      check("halt_rst_ir", 32'(dut.r_ir), 32'h0);
      check("halt_rst_state", 32'(dut.r_state), 32'(FETCH));

      // CMP
      begin_reset();
      load(12'h000, 16'h00F0);
      load(12'h003, 16'h1000); load(12'h004, 16'h7000);
      expect_mem(12'h000, 16'hFF0F, "cmp_m0");
      release_rst();
      run_to_halt(4, "cmp_cycles");
      drain();

      // MOV, first interrupted by reset in EXEC2, then run to completion.
      begin_reset();
      load(12'h003, 16'h3080); load(12'h004, 16'h0081);
      load(12'h005, 16'h7000); load(12'h081, 16'hABCD);
      release_rst();
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("mov_in_exec2", 32'(dut.r_state), 32'(EXEC2));
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("mov_abandoned", 32'(dut.M1.memory[12'h080]), 32'h0);
      check("mov_rst_pc", 32'(dut.r_pc), 32'h003);
      check("mov_rst_state", 32'(dut.r_state), 32'(FETCH));
      rst = 1'b0;
      expect_mem(12'h080, 16'hABCD, "mov_dest");
      expect_mem(12'h081, 16'hABCD, "mov_src_kept");
      run_to_halt(5, "mov_cycles");
      drain();

      // JMZ taken / not taken, JMN taken / not taken.
      begin_reset();
      load(12'h000, 16'h0000); load(12'h003, 16'h5009);
      release_rst();
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("jmz_taken_pc", 32'(dut.r_pc), 32'h009);

      begin_reset();
      load(12'h000, 16'h0001); load(12'h003, 16'h5009);
      release_rst();
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("jmz_not_taken_pc", 32'(dut.r_pc), 32'h004);

      begin_reset();
      load(12'h000, 16'h8000); load(12'h003, 16'h600A);
      release_rst();
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("jmn_taken_pc", 32'(dut.r_pc), 32'h00A);

      begin_reset();
      load(12'h000, 16'h7FFF); load(12'h003, 16'h600A);
      release_rst();
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("jmn_not_taken_pc", 32'(dut.r_pc), 32'h004);

      // PC wrap: JMP to FFE, LDA with literal at FFF, HLT fetched from word 0.
      begin_reset();
      load(12'h000, 16'h7000);
      load(12'h003, 16'h4FFE);
      load(12'hFFE, 16'h2080); load(12'hFFF, 16'h1234);
      expect_mem(12'h080, 16'h1234, "wrap_lda");
      release_rst();
      run_to_halt(6, "wrap_cycles");
      check("wrap_pc", 32'(dut.r_pc), 32'h001);
      drain();

      // Self-modifying: LDA overwrites the next instruction with HLT.
      begin_reset();
      load(12'h000, 16'h5555);
      load(12'h003, 16'h2005); load(12'h004, 16'h7000);
      load(12'h005, 16'h1000); load(12'h006, 16'h7000);
      expect_mem(12'h005, 16'h7000, "smc_word");
      expect_mem(12'h000, 16'h5555, "smc_m0");
      release_rst();
      run_to_halt(4, "smc_cycles");
      drain();

      // ADD overflow, then reset from HALT re-runs the program.
      begin_reset();
      load(12'h000, 16'hFFFF); load(12'h001, 16'h0002);
      load(12'h003, 16'h0000); load(12'h004, 16'h7000);
      expect_mem(12'h000, 16'h0001, "add_wrap_m0");
      release_rst();
      run_to_halt(4, "add_wrap_cycles");
      drain();
      rst = 1'b1;
      expect_mem(12'h000, 16'h0003, "rerun_m0");
      expect_mem(12'h001, 16'h0002, "rerun_m1");
      release_rst();
      run_to_halt(4, "rerun_cycles");
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
